// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program counter with a return-address stack and single-level
//            interrupt entry/exit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int unsigned      WIDTH        = 16,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = 16'h00F0,
  parameter int unsigned      DEPTH        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic             i_irq,
  output logic [WIDTH-1:0] o_pc_out,
  output logic [WIDTH-1:0] o_pc_next,
  output logic             o_in_isr,
  output logic             o_irq_ack,
  output logic             o_stk_full,
  output logic             o_stk_empty,
  output logic             o_stk_err
);

  localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);
  localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STEP);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [c_CW-1:0]  r_count;
  logic             r_in_isr;
  logic             r_ack;
  logic             r_err;

  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_push_data;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_entry;
  logic             w_isr_clr;
  logic             w_err_set;

  assign w_seq   = r_pc + c_STEP;
  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_top   = r_stack[c_AW'(r_count - 1'b1)];

  // Single priority chain: only the winning action produces any side effect.
  always_comb begin
    w_pc_next   = w_seq;
    w_push_data = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_entry     = 1'b0;
    w_isr_clr   = 1'b0;
    w_err_set   = 1'b0;
    if (i_stall) begin
      w_pc_next = r_pc;
    end else if (i_irq && !r_in_isr) begin
      w_entry     = 1'b1;
      w_push      = 1'b1;
      w_push_data = r_pc;
      w_pc_next   = IRQ_VECTOR;
      w_err_set   = w_full;
    end else if (i_ret) begin
      w_isr_clr = r_in_isr;
      if (w_empty) begin
        w_err_set = 1'b1;
      end else begin
        w_pop     = 1'b1;
        w_pc_next = w_top;
      end
    end else if (i_call) begin
      w_push      = 1'b1;
      w_push_data = w_seq;
      w_pc_next   = i_jump_target;
      w_err_set   = w_full;
    end else if (i_jump) begin
      w_pc_next = i_jump_target;
    end else if (i_branch_taken) begin
      w_pc_next = i_branch_target;
    end
  end

  // Stack storage needs no reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_full) begin
      r_stack[c_AW'(r_count)] <= w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_VECTOR;
      r_count  <= '0;
      r_in_isr <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_ack <= w_entry;
      if (w_push && !w_full) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_entry) begin
        r_in_isr <= 1'b1;
      end else if (w_isr_clr) begin
        r_in_isr <= 1'b0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_pc_out    = r_pc;
  assign o_pc_next   = w_pc_next;
  assign o_in_isr    = r_in_isr;
  assign o_irq_ack   = r_ack;
  assign o_stk_full  = w_full;
  assign o_stk_empty = w_empty;
  assign o_stk_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, call, ret, irq;
  logic [15:0] branch_target, jump_target;
  logic [15:0] pc, pc_next;
  logic        in_isr, irq_ack, full, empty, err;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (stall),
    .i_branch_taken (branch_taken),
    .i_branch_target(branch_target),
    .i_jump         (jump),
    .i_jump_target  (jump_target),
    .i_call         (call),
    .i_ret          (ret),
    .i_irq          (irq),
    .o_pc_out       (pc),
    .o_pc_next      (pc_next),
    .o_in_isr       (in_isr),
    .o_irq_ack      (irq_ack),
    .o_stk_full     (full),
    .o_stk_empty    (empty),
    .o_stk_err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; irq = 0;
    branch_target = 16'h0; jump_target = 16'h0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
    n_checks++; if ({empty, full, in_isr, irq_ack, err} !== 5'b10000) begin n_fail++; $display("FAIL rst_flags: got %b want 10000", {empty, full, in_isr, irq_ack, err}); end
    n_checks++; if (pc_next !== 16'h0001) begin n_fail++; $display("FAIL rst_pcnext: got %h want 0001", pc_next); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (pc !== 16'(i)) begin n_fail++; $display("FAIL seq%0d: got %h want %h", i, pc, 16'(i)); end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    jump = 1; jump_target = 16'h0010; tick(); jump = 0;
    n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL jump: got %h want 0010", pc); end
    call = 1; jump_target = 16'h0100; tick(); call = 0;
    n_checks++; if (pc !== 16'h0100 || empty !== 1'b0) begin n_fail++; $display("FAIL call: got pc %h empty %b want 0100 0", pc, empty); end
    ret = 1; tick(); ret = 0;
    n_checks++; if (pc !== 16'h0011 || empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL ret: got pc %h empty %b err %b want 0011 1 0", pc, empty, err); end
  endtask

  task automatic test_nested();
    logic [15:0] exp_ret [4];
    exp_ret = '{16'h3001, 16'h2001, 16'h1001, 16'h0001};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      call = 1; jump_target = 16'(i * 16'h1000); tick();
    end
    call = 0;
    n_checks++; if (pc !== 16'h4000 || full !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL call4: got pc %h full %b err %b want 4000 1 0", pc, full, err); end
    call = 1; jump_target = 16'h5000; tick(); call = 0;
    n_checks++; if (pc !== 16'h5000 || full !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL overflow: got pc %h full %b err %b want 5000 1 1", pc, full, err); end
    for (int i = 0; i < 4; i++) begin
      ret = 1; tick(); ret = 0;
      n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ret%0d: got %h want %h", i, pc, exp_ret[i]); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_after_rets: got %b want 1", empty); end
    ret = 1; tick(); ret = 0;
    n_checks++; if (pc !== 16'h0002 || empty !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL underflow: got pc %h empty %b err %b want 0002 1 1", pc, empty, err); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_irq();
    do_reset();
    jump = 1; jump_target = 16'h0020; tick(); jump = 0;
    irq = 1; tick();
    n_checks++; if (pc !== 16'h00F0 || in_isr !== 1'b1 || irq_ack !== 1'b1) begin n_fail++; $display("FAIL irq_entry: got pc %h isr %b ack %b want 00F0 1 1", pc, in_isr, irq_ack); end
    tick();
    n_checks++; if (pc !== 16'h00F1 || in_isr !== 1'b1 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_nonest: got pc %h isr %b ack %b want 00F1 1 0", pc, in_isr, irq_ack); end
    irq = 0; ret = 1; tick(); ret = 0;
    n_checks++; if (pc !== 16'h0020 || in_isr !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL reti: got pc %h isr %b empty %b want 0020 0 1", pc, in_isr, empty); end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1; jump = 1; jump_target = 16'h0ABC; irq = 1; #1;
    n_checks++; if (pc_next !== 16'h0000) begin n_fail++; $display("FAIL stall_pcnext: got %h want 0000", pc_next); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (pc !== 16'h0000 || in_isr !== 1'b0) begin n_fail++; $display("FAIL stall%0d: got pc %h isr %b want 0000 0", i, pc, in_isr); end
    end
    stall = 0; tick();
    n_checks++; if (pc !== 16'h00F0 || in_isr !== 1'b1) begin n_fail++; $display("FAIL stall_release: got pc %h isr %b want 00F0 1", pc, in_isr); end
    stall = 1; rst = 1; tick(); rst = 0; clr_inputs();
    n_checks++; if (pc !== 16'h0000 || in_isr !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL rst_override: got pc %h isr %b empty %b want 0000 0 1", pc, in_isr, empty); end
  endtask

  task automatic test_wrap();
    do_reset();
    jump = 1; jump_target = 16'hFFFF; tick(); jump = 0;
    tick();
    n_checks++; if (pc !== 16'h0000 || err !== 1'b0) begin n_fail++; $display("FAIL wrap: got pc %h err %b want 0000 0", pc, err); end
    jump = 1; jump_target = 16'hFFFF; tick(); jump = 0;
    call = 1; jump_target = 16'h0200; tick(); call = 0;
    n_checks++; if (pc !== 16'h0200) begin n_fail++; $display("FAIL wrap_call: got %h want 0200", pc); end
    ret = 1; tick(); ret = 0;
    n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_ret: got %h want 0000", pc); end
  endtask

  task automatic test_priority();
    do_reset();
    jump = 1; jump_target = 16'h0300; branch_taken = 1; branch_target = 16'h0400; tick();
    n_checks++; if (pc !== 16'h0300) begin n_fail++; $display("FAIL jump_over_branch: got %h want 0300", pc); end
    jump = 0; tick();
    n_checks++; if (pc !== 16'h0400) begin n_fail++; $display("FAIL branch: got %h want 0400", pc); end
    branch_taken = 0; call = 1; jump = 1; jump_target = 16'h0500; tick(); jump = 0;
    n_checks++; if (pc !== 16'h0500 || empty !== 1'b0) begin n_fail++; $display("FAIL call_over_jump: got pc %h empty %b want 0500 0", pc, empty); end
    ret = 1; branch_taken = 1; tick(); clr_inputs();
    n_checks++; if (pc !== 16'h0401 || empty !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL ret_over_call: got pc %h empty %b err %b want 0401 1 0", pc, empty, err); end
  endtask

  initial begin
    rst = 1;
    clr_inputs();
    test_reset();
    test_call_ret();
    test_nested();
    test_irq();
    test_stall();
    test_wrap();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Parameters
REQ-001 WIDTH, 16, PC width in bits.
REQ-002 STEP, 1, sequential increment per instruction.
REQ-003 RESET_VECTOR, 16'h0000, PC value after reset.
REQ-004 IRQ_VECTOR, 16'h00F0, PC loaded on interrupt entry.
REQ-005 DEPTH, 4, return-address stack entries (power of two, >=2).

Interface
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 stall  in  1  hold PC and stack; all control inputs ignored.
REQ-009 branch_taken  in  1  load branch_target.
REQ-010 branch_target  in  WIDTH  branch destination.
REQ-011 jump  in  1  load jump_target.
REQ-012 jump_target  in  WIDTH  jump/call destination.
REQ-013 call  in  1  push pc_out+STEP, load jump_target.
REQ-014 ret  in  1  pop stack into PC.
REQ-015 irq  in  1  level interrupt request.
REQ-016 pc_out  out  WIDTH  registered current PC.
REQ-017 pc_next  out  WIDTH  combinational PC for the next edge.
REQ-018 in_isr  out  1  interrupt service active.
REQ-019 irq_ack  out  1  one-cycle pulse on the cycle after interrupt entry.
REQ-020 stk_full, stk_empty  out  1 each  stack status, combinational from count.
REQ-021 stk_err  out  1  sticky overflow/underflow flag.

Function
REQ-022 PC updates only on rising clk; pc_out <= pc_next each cycle.
REQ-023 Priority, highest first: rst, stall, interrupt entry, ret, call, jump, branch_taken, sequential.
REQ-024 Sequential: pc_next = pc_out + STEP, modulo 2^WIDTH; FFFF+1 wraps to 0000 without a flag.
REQ-025 Interrupt entry when irq=1 and in_isr=0 and stall=0: push pc_out (the pending instruction is re-executed on return), load IRQ_VECTOR, set in_isr.
REQ-026 irq is ignored while in_isr=1; interrupts do not nest.
REQ-027 ret while in_isr=1: pop to PC, clear in_isr (return-from-interrupt).
REQ-028 ret while in_isr=0: pop to PC (subroutine return).
REQ-029 call: push (pc_out+STEP) mod 2^WIDTH, load jump_target; single cycle.
REQ-030 Stack is LIFO, count 0..DEPTH; push and pop never occur in the same cycle.
REQ-031 Push when full (call or interrupt entry): entry dropped, count unchanged, stk_err set; PC still loads its target.
REQ-032 Pop when empty: PC takes the sequential value, count stays 0, stk_err set; in_isr still clears if set.
REQ-033 Multiple control inputs asserted together: only the highest-priority action takes effect; the others are discarded without error.
REQ-034 stall=1 freezes pc_out, stack, in_isr and stk_err; pc_next = pc_out; an irq pending during stall is taken on the first unstalled cycle.
REQ-035 stk_err clears only on rst.

Reset
REQ-036 When rst=1 at a rising edge, the following take effect on that edge, overriding stall and all other inputs: pc_out=RESET_VECTOR, stack count=0, in_isr=0, irq_ack=0, stk_err=0.
REQ-037 After reset: stk_empty=1, stk_full=0; stack contents are don't-care.
REQ-038 rst asserted mid-ISR or mid-call discards all saved return addresses.

Verification
REQ-039 Reset, then 3 free-running cycles -> pc_out 0000, 0001, 0002, 0003.
REQ-040 At pc 0010: call with jump_target 0100 -> pc 0100; ret -> pc 0011, stk_empty=1.
REQ-041 Five nested calls at DEPTH=4 -> fifth call loads target, stk_err=1; four rets return correct addresses; fifth ret -> sequential value, stk_empty=1.
REQ-042 irq at pc 0020 -> pc 00F0, in_isr=1, irq_ack pulse; irq held high does not re-enter; ret -> pc 0020, in_isr=0.
REQ-043 stall held 3 cycles with jump=1 and irq=1 -> pc frozen; on release, irq wins -> pc 00F0.
REQ-044 pc FFFF, sequential -> 0000; call at FFFF pushes 0000.
